mips_mc_controller: RTL and testbench

MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

---
 rtl/mips_mc_controller.sv | 172 +++++++++++++++++
 tb/tb_mips_mc_controller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM: Moore-decoded datapath strobes, memory wait timeout, sticky error.
// Optional JUMP support is enabled by defining MIPS_MC_JUMP_EN.
module mips_mc_controller #(
   parameter int unsigned MEM_WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_opsel,
   output logic [1:0] pc_source,
   output logic [3:0] state,
   output logic       mem_err
);

   localparam int unsigned CW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StExec   = 4'd6,
      StAluWb  = 4'd7,
      StBranch = 4'd8,
`ifdef MIPS_MC_JUMP_EN
      StJump   = 4'd9,
`endif
      StError  = 4'd10
   } state_e;

   state_e        state_q;
   logic          run_q;
   logic [CW-1:0] wait_q;
   logic          mem_state;
   logic          timeout;
   logic          unused_zero;

   // Branch resolution happens in the datapath; the controller never looks at the flag.
   assign unused_zero = zero;

   assign mem_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
   assign timeout   = (MEM_WAIT_MAX != 0) && mem_state && !mem_ready &&
                      (wait_q == CW'(MEM_WAIT_MAX));

   // run_q holds the machine idle for the release cycle so the first fetch starts on the
   // first rising edge after reset. Memory states only exit with mem_ready=1, which clears
   // the counter, so it is zero on every entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StFetch;
         wait_q  <= '0;
         run_q   <= 1'b0;
      end else if (!run_q) begin
         run_q <= 1'b1;
      end else if (timeout) begin
         state_q <= StError;
      end else begin
         if (mem_state && !mem_ready) wait_q <= wait_q + 1'b1;
         else                         wait_q <= '0;
         case (state_q)
            StFetch:  if (mem_ready) state_q <= StDecode;
            StDecode: begin
               case (opcode)
                  6'h23, 6'h2B: state_q <= StMemAdr;
                  6'h00:        state_q <= StExec;
                  6'h04:        state_q <= StBranch;
`ifdef MIPS_MC_JUMP_EN
                  6'h02:        state_q <= StJump;
`endif
                  default:      state_q <= StError;
               endcase
            end
            StMemAdr: state_q <= (opcode == 6'h23) ? StMemRd : StMemWr;
            StMemRd:  if (mem_ready) state_q <= StMemWb;
            StMemWb:  state_q <= StFetch;
            StMemWr:  if (mem_ready) state_q <= StFetch;
            StExec:   state_q <= StAluWb;
            StAluWb:  state_q <= StFetch;
            StBranch: state_q <= StFetch;
`ifdef MIPS_MC_JUMP_EN
            StJump:   state_q <= StFetch;
`endif
            StError:  state_q <= StError;
            default:  state_q <= StError;
         endcase
      end
   end

   assign state = state_q;

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_opsel     = 2'b00;
      pc_source     = 2'b00;
      mem_err       = 1'b0;
      if (run_q) begin
         unique case (state_q)
            StFetch: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            StDecode: alu_src_b = 2'b11;
            StMemAdr: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            StMemRd: begin
               mem_read = 1'b1;
               iord     = 1'b1;
            end
            StMemWb: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            StMemWr: begin
               mem_write = 1'b1;
               iord      = 1'b1;
            end
            StExec: begin
               alu_src_a = 1'b1;
               alu_opsel = 2'b10;
            end
            StAluWb: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            StBranch: begin
               alu_src_a     = 1'b1;
               alu_opsel     = 2'b01;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
            end
`ifdef MIPS_MC_JUMP_EN
            StJump: begin
               pc_write  = 1'b1;
               pc_source = 2'b10;
            end
`endif
            StError: mem_err = 1'b1;
            default: mem_err = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: directed scenarios plus random instruction streams
// checked against an instruction-level phase model and per-state output table.
module tb_mips_mc_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_opsel, pc_source;
   logic [3:0] state;
   logic       mem_err;

   int         tests = 0;
   int         fails = 0;
   logic [5:0] cur_op = 6'h00;
   logic [16:0] obs;

   mips_mc_controller #(.MEM_WAIT_MAX(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_opsel(alu_opsel), .pc_source(pc_source), .state(state), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_dst, reg_write, alu_src_a, alu_src_b, alu_opsel, pc_source, mem_err};

   // Output table per state, straight from the control-signal listing.
   function automatic logic [16:0] exp_out(input int s, input logic rdy);
      logic pcw, pcwc, io, mr, mw, irw, m2r, rd, rw, sa, me;
      logic [1:0] sb, op, ps;
      {pcw, pcwc, io, mr, mw, irw, m2r, rd, rw, sa, me} = '0;
      sb = 2'b00; op = 2'b00; ps = 2'b00;
      case (s)
         0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
         1:  sb = 2'b11;
         2:  begin sa = 1; sb = 2'b10; end
         3:  begin mr = 1; io = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mw = 1; io = 1; end
         6:  begin sa = 1; op = 2'b10; end
         7:  begin rw = 1; rd = 1; end
         8:  begin sa = 1; op = 2'b01; pcwc = 1; ps = 2'b01; end
         9:  begin pcw = 1; ps = 2'b10; end
         10: me = 1;
         default: ;
      endcase
      return {pcw, pcwc, io, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps, me};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive inputs on the falling edge, check just after, then take the rising edge.
   task automatic cyc(input logic rdy, input int s);
      @(negedge clk);
      opcode    = cur_op;
      mem_ready = rdy;
      zero      = 1'($urandom);
      #1;
      chk($sformatf("state(exp %0d)", s), 32'(state), s);
      chk($sformatf("outputs(st %0d rdy %0b)", s, rdy), 32'(obs), 32'(exp_out(s, rdy)));
      @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      mem_ready = 1'($urandom);
      #1;
      chk("reset_state", 32'(state), 0);
      chk("reset_outputs", 32'(obs), 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("release_outputs", 32'(obs), 0);
      @(posedge clk);
   endtask

   // Instruction-level model: phase list per opcode, random waits on memory phases.
   task automatic run_instr(input logic [5:0] op, input int maxw);
      int ph[$];
      case (op)
         6'h23:   ph = '{0, 1, 2, 3, 4};
         6'h2B:   ph = '{0, 1, 2, 5};
         6'h00:   ph = '{0, 1, 6, 7};
         6'h04:   ph = '{0, 1, 8};
`ifdef MIPS_MC_JUMP_EN
         6'h02:   ph = '{0, 1, 9};
`endif
         default: ph = '{0, 1, 10};
      endcase
      cur_op = op;
      foreach (ph[i]) begin
         if (ph[i] == 0 || ph[i] == 3 || ph[i] == 5) begin
            int w = $urandom_range(0, maxw);
            repeat (w) cyc(1'b0, ph[i]);
            cyc(1'b1, ph[i]);
         end else if (ph[i] == 10) begin
            cyc(1'($urandom), 10);
            cyc(1'($urandom), 10);
            do_reset();
         end else begin
            cyc(1'($urandom), ph[i]);
         end
      end
   endtask

   initial begin
      logic [5:0] pool [6];
      pool = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h3F};
      rst = 1'b1; mem_ready = 1'b0; opcode = 6'h00; zero = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("initial_reset_state", 32'(state), 0);
      chk("initial_reset_outputs", 32'(obs), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("initial_release_outputs", 32'(obs), 0);
      @(posedge clk);

      // lw, zero wait: 0,1,2,3,4 then back to fetch
      run_instr(6'h23, 0);

      // R-type with three fetch wait cycles
      cur_op = 6'h00;
      repeat (3) cyc(1'b0, 0);
      cyc(1'b1, 0);
      cyc(1'b0, 1);
      cyc(1'b0, 6);
      cyc(1'b1, 7);

      run_instr(6'h04, 0);

      // sw with mem_ready stuck low: error after five MEMWR cycles
      cur_op = 6'h2B;
      cyc(1'b1, 0); cyc(1'b1, 1); cyc(1'b1, 2);
      repeat (5) cyc(1'b0, 5);
      cyc(1'b0, 10);
      cyc(1'b1, 10);
      do_reset();

      // sw completing in the fifth cycle: completion wins
      cur_op = 6'h2B;
      cyc(1'b1, 0); cyc(1'b1, 1); cyc(1'b1, 2);
      repeat (4) cyc(1'b0, 5);
      cyc(1'b1, 5);
      run_instr(6'h23, 2);

      // fetch timeout
      repeat (5) cyc(1'b0, 0);
      cyc(1'b0, 10);
      do_reset();

      run_instr(6'h02, 1);
      run_instr(6'h3F, 1);

      // reset in the middle of a load's MEMRD
      cur_op = 6'h23;
      cyc(1'b1, 0); cyc(1'b1, 1); cyc(1'b1, 2); cyc(1'b0, 3);
      do_reset();
      run_instr(6'h23, 1);

      for (int n = 0; n < 60; n++) begin
         logic [5:0] op;
         if ($urandom_range(0, 7) == 0) op = 6'($urandom);
         else                           op = pool[$urandom_range(0, 5)];
         run_instr(op, 4);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
